// File: rtl/inst_loader.sv
// Boot-time instruction memory loader: header byte N, then N big-endian words.
// Optional checksum byte after the data when INST_LOADER_CHECKSUM_EN is defined.
module inst_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [7:0]        word_cnt,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam logic [8:0] DEPTH9 = 9'(1 << ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
`ifdef INST_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t END_ST = S_CHK;
`else
  localparam state_t END_ST = S_DONE;
`endif

  state_t      state, state_nxt;
  logic [7:0]  n;
  logic [7:0]  widx;
  logic [1:0]  byte_cnt;
  logic        in_range;
  logic        restart;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign in_range = ({1'b0, widx} < DEPTH9);
  assign restart  = start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_HDR;
      S_HDR:   if (byte_valid) state_nxt = (byte_data == 8'd0) ? END_ST : S_DATA;
      S_DATA:  if (byte_valid && byte_cnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (widx + 8'd1 == n) ? END_ST : S_DATA;
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHK:   if (byte_valid) state_nxt = S_DONE;
`endif
      S_DONE:  if (start) state_nxt = S_HDR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and strobes decode from registered state only, never from byte_valid.
  assign byte_ready = (state == S_HDR) || (state == S_DATA)
`ifdef INST_LOADER_CHECKSUM_EN
                      || (state == S_CHK)
`endif
                      ;
  assign mem_we   = (state == S_WRITE) && in_range;
  assign done     = (state == S_DONE);
  assign cpu_hold = !(done && !err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n         <= '0;
      widx      <= '0;
      byte_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
      err       <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      if (restart) begin
        widx     <= '0;
        byte_cnt <= '0;
        mem_addr <= '0;
        word_cnt <= '0;
        err      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end

      if (state == S_HDR && byte_valid) begin
        n <= byte_data;
        if ({1'b0, byte_data} > DEPTH9) err <= 1'b1;
      end

      if (state == S_DATA && byte_valid) begin
        mem_wdata <= {mem_wdata[23:0], byte_data};
        byte_cnt  <= byte_cnt + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
        csum      <= csum ^ byte_data;
`endif
      end

      // Words past capacity still advance the index so the stream is drained.
      if (state == S_WRITE) begin
        widx <= widx + 8'd1;
        if (in_range) word_cnt <= word_cnt + 8'd1;
        if (mem_addr != '1) mem_addr <= mem_addr + 1'b1;
      end

`ifdef INST_LOADER_CHECKSUM_EN
      if (state == S_CHK && byte_valid && byte_data != csum) err <= 1'b1;
`endif
    end
  end

endmodule
